// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared Blowfish state encoding and sizing constants.
package bcrypt_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, CALC, FINAL, DONE} blowfish_state_t;
  localparam int BF_ROUNDS = 16;
  localparam int BF_P_WORDS = 18;
  localparam int SBOX_ADDR_W = 8;
endpackage

// File: rtl/blowfish_f.sv
// blowfish_f: Blowfish round function from the four S-box words.
module blowfish_f (
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic [31:0] s3,
  input  logic [31:0] s4,
  output logic [31:0] f
);
  assign f = ((s1 + s2) ^ s3) + s4;
endmodule

// File: rtl/blowfish_encrypt.sv
// blowfish_encrypt: iterative Blowfish core, two cycles per round against synchronous S-box SRAMs.
module blowfish_encrypt
  import bcrypt_pkg::*;
#(
  parameter int ROUNDS = BF_ROUNDS,
  parameter int DATA_W = 32,
  parameter int ADDR_W = SBOX_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start,
  input  logic [DATA_W-1:0]          L,
  input  logic [DATA_W-1:0]          R,
  input  logic [32*(ROUNDS+2)-1:0]   p,
  input  logic [DATA_W-1:0]          s1_out,
  input  logic [DATA_W-1:0]          s2_out,
  input  logic [DATA_W-1:0]          s3_out,
  input  logic [DATA_W-1:0]          s4_out,
  output logic [ADDR_W-1:0]          s1_addr,
  output logic [ADDR_W-1:0]          s2_addr,
  output logic [ADDR_W-1:0]          s3_addr,
  output logic [ADDR_W-1:0]          s4_addr,
  output logic                       s1_cs_l,
  output logic                       s2_cs_l,
  output logic                       s3_cs_l,
  output logic                       s4_cs_l,
  output logic [DATA_W-1:0]          resultL,
  output logic [DATA_W-1:0]          resultR,
  output logic                       done
);
  blowfish_state_t state_q, state_d;
  logic [4:0] round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d, res_l_q, res_l_d, res_r_q, res_r_d;
  logic [31:0] p_w [ROUNDS+2];
  logic [31:0] xl, f;
  logic in_addr, last;
  for (genvar i = 0; i < ROUNDS + 2; i++) begin : g_p
    assign p_w[i] = p[32*i +: 32];
  end
  blowfish_f u_f (.s1(s1_out), .s2(s2_out), .s3(s3_out), .s4(s4_out), .f(f));
  assign xl = l_q ^ p_w[round_q];
  assign in_addr = state_q == ADDR;
  assign last = round_q == 5'(ROUNDS - 1);
  assign {s1_cs_l, s2_cs_l, s3_cs_l, s4_cs_l} = {4{!in_addr}};
  assign s1_addr = in_addr ? xl[31:24] : '0;
  assign s2_addr = in_addr ? xl[23:16] : '0;
  assign s3_addr = in_addr ? xl[15:8] : '0;
  assign s4_addr = in_addr ? xl[7:0] : '0;
  assign done = state_q == DONE;
  assign resultL = res_l_q;
  assign resultR = res_r_q;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    l_d = l_q;
    r_d = r_q;
    res_l_d = res_l_q;
    res_r_d = res_r_q;
    case (state_q)
      IDLE: if (start) begin
        l_d = L;
        r_d = R;
        round_d = '0;
        state_d = ADDR;
      end
      ADDR: begin
        l_d = xl;
        state_d = CALC;
      end
      CALC: begin
        l_d = r_q ^ f;
        r_d = l_q;
        round_d = last ? round_q : round_q + 5'd1;
        state_d = last ? FINAL : ADDR;
      end
      // the final un-swap is folded into which half feeds which result
      FINAL: begin
        res_l_d = r_q ^ p_w[ROUNDS+1];
        res_r_d = l_q ^ p_w[ROUNDS];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      round_q <= '0;
      l_q <= '0;
      r_q <= '0;
      res_l_q <= '0;
      res_r_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      l_q <= l_d;
      r_q <= r_d;
      res_l_q <= res_l_d;
      res_r_q <= res_r_d;
    end
  end
endmodule
